// File: rtl/integral_cache_arbiter_if.sv
// integral_cache_arbiter_if: frame, write, read, cache and status bundle.
// slave = arbiter side, master = requesters plus cache side.
interface integral_cache_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 20
);
    logic                  frame_start;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rd0_valid;
    logic                  rd0_ready;
    logic [ADDR_WIDTH-1:0] rd0_addr;
    logic                  rd0_rvalid;
    logic [DATA_WIDTH-1:0] rd0_rdata;

    logic                  rd1_valid;
    logic                  rd1_ready;
    logic [ADDR_WIDTH-1:0] rd1_addr;
    logic                  rd1_rvalid;
    logic [DATA_WIDTH-1:0] rd1_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic [15:0]           stat_wr_cnt;
    logic [15:0]           stat_rd0_cnt;
    logic [15:0]           stat_rd1_cnt;

    modport slave (
        input  frame_start,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd0_valid, rd0_addr,
        output rd0_ready, rd0_rvalid, rd0_rdata,
        input  rd1_valid, rd1_addr,
        output rd1_ready, rd1_rvalid, rd1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy,
        output stat_wr_cnt, stat_rd0_cnt, stat_rd1_cnt
    );

    modport master (
        output frame_start,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd0_valid, rd0_addr,
        input  rd0_ready, rd0_rvalid, rd0_rdata,
        output rd1_valid, rd1_addr,
        input  rd1_ready, rd1_rvalid, rd1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy,
        input  stat_wr_cnt, stat_rd0_cnt, stat_rd1_cnt
    );
endinterface

// File: rtl/integral_cache_arbiter.sv
// integral_cache_arbiter: one grant per cycle over one writer and two readers.
// Define INTEGRAL_ARB_STATS_EN to build the per-requester grant counters.
module integral_cache_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 20,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    integral_cache_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_Idle,
        S_Grant,
        S_Drain
    } state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    state_t state;
    state_t state_n;

    logic [SW-1:0] streak;
    logic [SW-1:0] streak_eff;
    logic [SW-1:0] streak_n;
    logic          ptr;
    logic          ptr_eff;
    logic          ptr_n;

    logic          rd_pend;
    logic          any_valid;
    logic          force_rd;
    logic          gnt_wr;
    logic          gnt_rd0;
    logic          gnt_rd1;
    logic          gnt_rd;

    // read granted last cycle, per port; its cache access is this cycle
    logic [1:0]    rd_p1;

    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    // Arbitration: frame_start clears streak/pointer before they are used
    always_comb begin
        streak_eff = bus.frame_start ? '0 : streak;
        ptr_eff    = bus.frame_start ? 1'b0 : ptr;
        rd_pend    = bus.rd0_valid | bus.rd1_valid;
        any_valid  = bus.wr_valid | rd_pend;
        force_rd   = rd_pend && (streak_eff == LIM);
        gnt_wr     = 1'b0;
        gnt_rd0    = 1'b0;
        gnt_rd1    = 1'b0;
        if (!reset) begin
            if (bus.wr_valid && !force_rd) begin
                gnt_wr = 1'b1;
            end else if (bus.rd0_valid && bus.rd1_valid) begin
                gnt_rd0 = !ptr_eff;
                gnt_rd1 = ptr_eff;
            end else begin
                gnt_rd0 = bus.rd0_valid;
                gnt_rd1 = bus.rd1_valid;
            end
        end
        gnt_rd = gnt_rd0 | gnt_rd1;

        ptr_n = ptr_eff;
        if (gnt_rd0) ptr_n = 1'b1;
        if (gnt_rd1) ptr_n = 1'b0;

        streak_n = '0;
        if (gnt_wr && rd_pend) begin
            streak_n = (streak_eff == LIM) ? streak_eff
                                           : streak_eff + SW'(1);
        end
    end

    assign bus.wr_ready  = gnt_wr;
    assign bus.rd0_ready = gnt_rd0;
    assign bus.rd1_ready = gnt_rd1;

    // Next state: Drain only waits for the read whose data is still to come
    always_comb begin
        state_n = state;
        unique case (state)
            S_Idle: begin
                if (any_valid) state_n = S_Grant;
            end
            S_Grant: begin
                if (!any_valid) begin
                    state_n = (|rd_p1) ? S_Drain : S_Idle;
                end
            end
            S_Drain: begin
                if (any_valid) state_n = S_Grant;
                else if (rd_p1 == 2'b00) state_n = S_Idle;
            end
            default: state_n = S_Idle;
        endcase
    end

    assign bus.busy = !reset && ((state != S_Idle) || any_valid);

    // State, arbitration history, cache command and read return pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_Idle;
            streak         <= '0;
            ptr            <= 1'b0;
            rd_p1          <= 2'b00;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.rd0_rvalid <= 1'b0;
            bus.rd1_rvalid <= 1'b0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
        end else begin
            state          <= state_n;
            streak         <= streak_n;
            ptr            <= ptr_n;
            rd_p1          <= {gnt_rd1, gnt_rd0};
            bus.mem_en     <= gnt_wr | gnt_rd;
            bus.mem_we     <= gnt_wr;
            bus.rd0_rvalid <= rd_p1[0];
            bus.rd1_rvalid <= rd_p1[1];
            if (gnt_wr) begin
                bus.mem_addr  <= bus.wr_addr;
                bus.mem_wdata <= bus.wr_data;
            end else if (gnt_rd0) begin
                bus.mem_addr  <= bus.rd0_addr;
            end else if (gnt_rd1) begin
                bus.mem_addr  <= bus.rd1_addr;
            end
            if (bus.rd0_rvalid) rdata0_q <= bus.mem_rdata;
            if (bus.rd1_rvalid) rdata1_q <= bus.mem_rdata;
        end
    end

    assign bus.rd0_rdata = bus.rd0_rvalid ? bus.mem_rdata : rdata0_q;
    assign bus.rd1_rdata = bus.rd1_rvalid ? bus.mem_rdata : rdata1_q;

`ifdef INTEGRAL_ARB_STATS_EN
    logic [15:0] cnt_wr;
    logic [15:0] cnt_rd0;
    logic [15:0] cnt_rd1;

    // Grant counters, wrapping, restarted each frame
    always_ff @(posedge clk) begin
        if (reset || bus.frame_start) begin
            cnt_wr  <= '0;
            cnt_rd0 <= '0;
            cnt_rd1 <= '0;
        end else begin
            cnt_wr  <= cnt_wr + {15'd0, gnt_wr};
            cnt_rd0 <= cnt_rd0 + {15'd0, gnt_rd0};
            cnt_rd1 <= cnt_rd1 + {15'd0, gnt_rd1};
        end
    end

    assign bus.stat_wr_cnt  = cnt_wr;
    assign bus.stat_rd0_cnt = cnt_rd0;
    assign bus.stat_rd1_cnt = cnt_rd1;
`else
    assign bus.stat_wr_cnt  = '0;
    assign bus.stat_rd0_cnt = '0;
    assign bus.stat_rd1_cnt = '0;
`endif
endmodule

// File: doc/integral_cache_arbiter.md
INTEGRAL_CACHE_ARBITER -- requirements
Module: integral_cache_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16; cache address width, equal to integral row bits plus integral column bits.
REQ-002 Parameter DATA_WIDTH, default 20; integral image word width.
REQ-003 Parameter STARVE_LIMIT, default 8; maximum number of consecutive write grants while a read is pending.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
REQ-005 Frame and write ports:
- frame_start  in  1  one-cycle pulse at the start of each frame.
- wr_valid  in  1  generator write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
REQ-006 Read ports, for N = 0 (feature evaluator) and N = 1 (variance normalizer):
- rdN_valid  in  1  read request.
- rdN_ready  out  1  read accepted this cycle.
- rdN_addr  in  ADDR_WIDTH  read address.
- rdN_rvalid  out  1  one-cycle pulse marking returned data.
- rdN_rdata  out  DATA_WIDTH  returned data.
REQ-007 Cache and status ports:
- mem_en  out  1  cache access enable.
- mem_we  out  1  cache write enable.
- mem_addr  out  ADDR_WIDTH  cache address.
- mem_wdata  out  DATA_WIDTH  cache write data.
- mem_rdata  in  DATA_WIDTH  cache read data, valid one cycle after mem_en with mem_we low.
- busy  out  1  high when any request is pending or any read is in flight.
- stat_wr_cnt  out  16  write grant count.
- stat_rd0_cnt  out  16  read port 0 grant count.
- stat_rd1_cnt  out  16  read port 1 grant count.

Function
REQ-008 The block SHALL grant at most one requester per cycle; a grant is signalled by the matching ready going high in the same cycle as its valid, so ready is combinational from valid and state.
REQ-009 Priority SHALL be: write first, unless streak equals STARVE_LIMIT and a read is pending, in which case a read is granted.
REQ-010 Reads SHALL alternate round-robin: the pointer names the preferred port; after a read grant it moves to the other port; if only one port is valid, that port is granted.
REQ-011 The cycle after a grant, mem_en SHALL be 1 and mem_we, mem_addr and mem_wdata SHALL be registered copies of the granted request; in cycles with no grant, mem_en and mem_we SHALL be 0.
REQ-012 rdN_rvalid SHALL pulse exactly two cycles after rdN_ready, with rdN_rdata equal to mem_rdata in that cycle; rdN_rdata SHALL hold its last value otherwise.
REQ-013 The write streak counter SHALL increment on a write grant only when a read is pending, saturate at STARVE_LIMIT, and clear on any read grant or on any cycle with no read pending.
REQ-014 A write and a read to the same address SHALL be executed in grant order; a read granted one cycle after the write returns the new data.
REQ-015 frame_start SHALL clear the streak and set the pointer to 0; a grant in that same cycle SHALL be evaluated with the cleared values.
REQ-016 The FSM SHALL have states S_Idle (no requests, nothing in flight), S_Grant (issuing accesses) and S_Drain (no new grant, reads in flight). Transitions: S_Idle to S_Grant on any valid; S_Grant to S_Drain when no valid and a read is in flight; S_Grant to S_Idle when no valid and nothing is in flight; S_Drain to S_Idle when the last rvalid fires; S_Drain to S_Grant on any valid. busy SHALL be 0 only in S_Idle.
REQ-017 A requester SHALL hold valid, addr and data stable until ready; the block SHALL NOT depend on a requester withdrawing a request.

Reset
REQ-018 On reset the block SHALL set all ready, mem_en, mem_we, rvalid and busy outputs to 0; clear mem_addr, mem_wdata, rdata, the streak, the pointer, the in-flight pipeline and the stat counters to 0; and enter S_Idle.
REQ-019 Reset asserted mid-operation SHALL discard in-flight reads, with no later rvalid pulse for them.

Configuration
REQ-020 With INTEGRAL_ARB_STATS_EN defined, the stat counters SHALL increment on each grant of their requester, wrap at 16 bits and clear on frame_start; without the macro, the stat outputs SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-021 Write-only stream: wr_valid held for 5 cycles -> wr_ready high all 5 cycles, mem_we=1 on cycles 2-6, busy falls after the last write.
REQ-022 Read round-robin: rd0 and rd1 both valid for 4 cycles, no writes -> grants go rd0, rd1, rd0, rd1, each rvalid 2 cycles after its grant with mem_rdata returned.
REQ-023 Starvation: wr_valid continuous with rd0_valid raised, STARVE_LIMIT=8 -> 8 write grants, then rd0_ready, then writes resume.
REQ-024 Hazard: write addr 0x0012 with data 0x3ABCD, then a read of 0x0012 in the next cycle -> rd0_rdata=0x3ABCD.
REQ-025 Reset mid-read: reset asserted the cycle after rd1_ready -> no rd1_rvalid pulse, all outputs 0, state S_Idle.
REQ-026 Stats: with INTEGRAL_ARB_STATS_EN defined, 3 writes and 2 rd0 reads -> stat_wr_cnt=3, stat_rd0_cnt=2, stat_rd1_cnt=0; frame_start -> all 0.
